// File: rtl/risc_pkg.sv
// Shared constants for the execute stage: code points, packet field positions,
// and the format-dependent operand-B selector.
package risc_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned IN_W   = 58;
    localparam int unsigned OUT_W  = 42;

    localparam int unsigned IN_FMT_LSB  = 0;
    localparam int unsigned IN_OP_LSB   = 2;
    localparam int unsigned IN_COND_LSB = 5;
    localparam int unsigned IN_CTRL_W   = 7;
    localparam int unsigned IN_DEST_LSB = 10;
    localparam int unsigned IN_B_LSB    = 26;
    localparam int unsigned IN_A_LSB    = 42;

    localparam int unsigned IMM6_W = 6;
    localparam int unsigned IMM9_W = 9;

    localparam int unsigned OUT_CTRL_LSB = 0;
    localparam int unsigned OUT_RES_LSB  = 7;
    localparam int unsigned OUT_WR_BIT   = 23;
    localparam int unsigned OUT_C_BIT    = 24;
    localparam int unsigned OUT_Z_BIT    = 25;
    localparam int unsigned OUT_B_LSB    = 26;

    typedef enum logic [1:0] {
        FMT_NOP = 2'b00,
        FMT_J   = 2'b01,
        FMT_I   = 2'b10,
        FMT_R   = 2'b11
    } fmt_e;

    // Codes 101-111 are not listed; the ALU treats them as ADD.
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_NAND = 3'b001,
        OP_SUB  = 3'b010,
        OP_LHI  = 3'b011,
        OP_PASS = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        COND_ALWAYS  = 2'b00,
        COND_C       = 2'b01,
        COND_Z       = 2'b10,
        COND_ALWAYS2 = 2'b11
    } cond_e;

    function automatic logic [WORD_W-1:0] sel_operand_b(input logic [1:0] fmt,
                                                        input logic [WORD_W-1:0] raw);
        case (fmt)
            FMT_I:   return {{(WORD_W-IMM6_W){raw[IMM6_W-1]}}, raw[IMM6_W-1:0]};
            FMT_J:   return {{(WORD_W-IMM9_W){raw[IMM9_W-1]}}, raw[IMM9_W-1:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_alu16.sv
// Combinational 16-bit ALU; carry is meaningful for ADD-class ops only.
module alu16
    import risc_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic [IMM9_W-1:0] imm9_i,
    output logic [WORD_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [WORD_W:0] sum;

    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[WORD_W-1:0];
        carry_o  = 1'b0;
        case (op_i)
            OP_NAND: result_o = ~(a_i & b_i);
            OP_SUB:  result_o = a_i - b_i;
            OP_LHI:  result_o = {imm9_i, {(WORD_W-IMM9_W){1'b0}}};
            OP_PASS: result_o = b_i;
            default: carry_o  = sum[WORD_W];
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/execute_stage.sv
// Single-entry execute stage: conditional ALU op, C/Z flag state and a
// valid/ready output register.
module execute_stage
    import risc_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  InData,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] outData
);

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             c_q, c_d, z_q, z_d;

    logic [1:0]        fmt;
    logic [2:0]        op;
    logic [1:0]        cond;
    logic [WORD_W-1:0] opnd_a, opnd_b, old_dest;
    logic [WORD_W-1:0] alu_res, res;
    logic              alu_c, alu_z;
    logic              cond_ok, wr_en, c_exec, z_exec;
    logic              accept, issue;
    logic [OUT_W-1:0]  pkt;
    logic              unused_rsvd;

    assign fmt         = InData[IN_FMT_LSB +: 2];
    assign op          = InData[IN_OP_LSB +: 3];
    assign cond        = InData[IN_COND_LSB +: 2];
    assign opnd_a      = InData[IN_A_LSB +: WORD_W];
    assign old_dest    = InData[IN_DEST_LSB +: WORD_W];
    assign opnd_b      = sel_operand_b(fmt, InData[IN_B_LSB +: WORD_W]);
    assign unused_rsvd = ^InData[IN_DEST_LSB-1:IN_CTRL_W];

    alu16 u_alu (
        .op_i     (op),
        .a_i      (opnd_a),
        .b_i      (opnd_b),
        .imm9_i   (InData[IN_B_LSB +: IMM9_W]),
        .result_o (alu_res),
        .carry_o  (alu_c),
        .zero_o   (alu_z)
    );

    // Result packet and the flag values it would commit, from the current flags.
    always_comb begin
        cond_ok = 1'b1;
        case (cond)
            COND_C:  cond_ok = c_q;
            COND_Z:  cond_ok = z_q;
            default: cond_ok = 1'b1;
        endcase
        res    = alu_res;
        wr_en  = (op != OP_SUB);
        c_exec = c_q;
        z_exec = z_q;
        if (!cond_ok) begin
            res   = old_dest;
            wr_en = 1'b0;
        end else begin
            case (op)
                OP_NAND, OP_SUB: z_exec = alu_z;
                OP_LHI, OP_PASS: ;
                default: begin
                    c_exec = alu_c;
                    z_exec = alu_z;
                end
            endcase
        end
        pkt = {opnd_b, z_exec, c_exec, wr_en, res, InData[IN_CTRL_W-1:0]};
    end

    assign in_ready = resetn && (!out_valid_q || out_ready);

    always_comb begin
        accept      = in_valid && in_ready && !flush;
        issue       = accept && (fmt != FMT_NOP);
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        c_d         = c_q;
        z_d         = z_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = issue;
            if (issue) begin
                out_data_d = pkt;
                c_d        = c_exec;
                z_d        = z_exec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            c_q         <= c_d;
            z_q         <= z_d;
        end
    end

    assign out_valid = out_valid_q;
    assign outData   = out_data_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, hand-written stall/flush/reset
// sequences, and randomized traffic against a packet-level reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [57:0] InData;
    logic [41:0] outData;

    int checks = 0;
    int failures = 0;

    execute_stage dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .InData    (InData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outData   (outData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [2:0]  op;
        logic [1:0]  cond;
        logic [15:0] a;
        logic [15:0] braw;
        logic [15:0] dest;
        logic [15:0] res;
        logic        wr;
        logic        c;
        logic        z;
        logic [15:0] bsel;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [57:0] mk(input logic [1:0] fmt, input logic [2:0] op,
                                       input logic [1:0] cond, input logic [15:0] a,
                                       input logic [15:0] braw, input logic [15:0] dest);
        return {a, braw, dest, 3'b000, cond, op, fmt};
    endfunction

    // Reference model: executes one packet from the architectural rules.
    function automatic void ref_exec(input logic [57:0] d, input bit c, input bit z,
                                     output bit emit, output logic [41:0] o,
                                     output bit nc, output bit nz);
        int unsigned fmt, op, cond, a, b, dest, res, sum;
        bit run, wr;
        fmt  = 32'(d[1:0]);
        op   = 32'(d[4:2]);
        cond = 32'(d[6:5]);
        a    = 32'(d[57:42]);
        dest = 32'(d[25:10]);
        nc   = c;
        nz   = z;
        emit = (fmt != 0);
        case (fmt)
            3: b = 32'(d[41:26]);
            2: begin b = 32'(d[31:26]); if (b >= 32)  b = b + 65536 - 64;  end
            1: begin b = 32'(d[34:26]); if (b >= 256) b = b + 65536 - 512; end
            default: b = 0;
        endcase
        run = (cond == 0) || (cond == 3) || (cond == 1 && c) || (cond == 2 && z);
        wr  = 1'b1;
        res = 0;
        if (!run) begin
            res = dest;
            wr  = 1'b0;
        end else begin
            case (op)
                1: begin res = 65535 - (a & b); nz = (res == 0); end
                2: begin res = (a + 65536 - b) % 65536; wr = 1'b0; nz = (a == b); end
                3: res = 32'(d[34:26]) * 128;
                4: res = b;
                default: begin
                    sum = a + b;
                    res = sum % 65536;
                    nc  = (sum > 65535);
                    nz  = (res == 0);
                end
            endcase
        end
        o = {b[15:0], nz, nc, wr, res[15:0], d[6:0]};
    endfunction

    function automatic logic [15:0] rnd_word();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic do_reset();
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        InData    = '0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outData", 64'(outData), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        resetn = 1'b1;
    endtask

    vec_t tbl[11];

    initial begin
        logic [41:0] d1, d2, exp_data, o;
        bit          emit, nc, nz, ec, ez, exp_valid, rdy;

        tbl[0]  = '{2'b11, 3'd0, 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0001};
        tbl[1]  = '{2'b11, 3'd0, 2'd1, 16'h0002, 16'h0003, 16'h0000, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0003};
        tbl[2]  = '{2'b11, 3'd0, 2'd1, 16'h0002, 16'h0003, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0003};
        tbl[3]  = '{2'b10, 3'd0, 2'd0, 16'h0005, 16'h003E, 16'h0000, 16'h0003, 1'b1, 1'b1, 1'b0, 16'hFFFE};
        tbl[4]  = '{2'b01, 3'd3, 2'd0, 16'h0000, 16'h01FF, 16'h0000, 16'hFF80, 1'b1, 1'b1, 1'b0, 16'hFFFF};
        tbl[5]  = '{2'b11, 3'd1, 2'd2, 16'h1234, 16'h00F0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h00F0};
        tbl[6]  = '{2'b11, 3'd2, 2'd0, 16'h0007, 16'h0007, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0007};
        tbl[7]  = '{2'b11, 3'd1, 2'd2, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFFFF};
        tbl[8]  = '{2'b11, 3'd4, 2'd3, 16'h0000, 16'hABCD, 16'h0000, 16'hABCD, 1'b1, 1'b1, 1'b1, 16'hABCD};
        tbl[9]  = '{2'b11, 3'd7, 2'd0, 16'h0001, 16'h0002, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0002};
        tbl[10] = '{2'b11, 3'd2, 2'd0, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0005};

        do_reset();

        // Back-to-back table: flags carry from one row to the next.
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            InData   = mk(tbl[i].fmt, tbl[i].op, tbl[i].cond, tbl[i].a, tbl[i].braw, tbl[i].dest);
            tick();
            exp_data = {tbl[i].bsel, tbl[i].z, tbl[i].c, tbl[i].wr, tbl[i].res,
                        tbl[i].cond, tbl[i].op, tbl[i].fmt};
            check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("tbl%0d_data", i), 64'(outData), 64'(exp_data));
        end
        in_valid = 1'b0;
        tick();
        check("tbl_drain", 64'(out_valid), 64'd0);

        // Stall: flags are C=0 Z=0 here.
        ref_exec(mk(2'b11, 3'd4, 2'd0, 16'h0000, 16'h1111, 16'h0000), 1'b0, 1'b0, emit, d1, nc, nz);
        ref_exec(mk(2'b11, 3'd0, 2'd0, 16'h0010, 16'h0020, 16'h0000), 1'b0, 1'b0, emit, d2, nc, nz);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        InData    = mk(2'b11, 3'd4, 2'd0, 16'h0000, 16'h1111, 16'h0000);
        tick();
        InData = mk(2'b11, 3'd0, 2'd0, 16'h0010, 16'h0020, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(outData), 64'(d1));
            check("stall_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        check("stall_hold_data", 64'(outData), 64'(d1));
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("release_valid", 64'(out_valid), 64'd1);
        check("release_data", 64'(outData), 64'(d2));
        tick();
        check("release_drain", 64'(out_valid), 64'd0);

        // Flush squashes an offered carry-producing ADD; C must stay 0.
        in_valid = 1'b1;
        flush    = 1'b1;
        InData   = mk(2'b11, 3'd0, 2'd0, 16'hFFFF, 16'h0001, 16'h0000);
        tick();
        check("flush_no_valid", 64'(out_valid), 64'd0);
        flush  = 1'b0;
        InData = mk(2'b11, 3'd0, 2'd1, 16'h0002, 16'h0003, 16'h5555);
        tick();
        check("flush_c_kept_valid", 64'(out_valid), 64'd1);
        check("flush_c_kept_data", 64'(outData),
              64'({16'h0003, 1'b0, 1'b0, 1'b0, 16'h5555, 7'h23}));

        // Flush of a held result.
        out_ready = 1'b0;
        InData    = mk(2'b11, 3'd4, 2'd0, 16'h0000, 16'h0007, 16'h0000);
        tick();
        check("held_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        tick();
        check("flush_held", 64'(out_valid), 64'd0);
        flush = 1'b0;

        // NOP is accepted and dropped.
        out_ready = 1'b1;
        InData    = mk(2'b00, 3'd0, 2'd0, 16'hFFFF, 16'h0001, 16'h0000);
        #1;
        check("nop_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("nop_no_valid", 64'(out_valid), 64'd0);

        // Reset mid-stall clears held packet and flags.
        out_ready = 1'b0;
        InData    = mk(2'b11, 3'd0, 2'd0, 16'hFFFF, 16'h0001, 16'h0000);
        tick();
        in_valid = 1'b0;
        check("pre_rst_c", 64'(outData[24]), 64'd1);
        tick();
        resetn = 1'b0;
        tick();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", 64'(outData), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        resetn    = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        InData    = mk(2'b11, 3'd0, 2'd1, 16'h0001, 16'h0001, 16'h0042);
        tick();
        check("postrst_c0", 64'(outData), 64'({16'h0001, 1'b0, 1'b0, 1'b0, 16'h0042, 7'h23}));
        InData = mk(2'b11, 3'd0, 2'd2, 16'h0001, 16'h0001, 16'h0099);
        tick();
        check("postrst_z0", 64'(outData), 64'({16'h0001, 1'b0, 1'b0, 1'b0, 16'h0099, 7'h43}));
        in_valid = 1'b0;
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        exp_valid = 1'b0;
        exp_data  = '0;
        ec        = 1'b0;
        ez        = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 5);
            out_ready = ($urandom_range(0, 99) < 65);
            InData    = {rnd_word(), rnd_word(), 16'($urandom), 3'($urandom),
                         2'($urandom), 3'($urandom), 2'($urandom)};
            #1;
            rdy = !exp_valid || out_ready;
            check("rnd_in_ready", 64'(in_ready), 64'(rdy));
            if (flush) begin
                exp_valid = 1'b0;
            end else if (in_valid && rdy) begin
                ref_exec(InData, ec, ez, emit, o, nc, nz);
                exp_valid = emit;
                if (emit) begin
                    exp_data = o;
                    ec       = nc;
                    ez       = nz;
                end
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
            tick();
            check("rnd_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid) check("rnd_data", 64'(outData), 64'(exp_data));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 flush  input  1  synchronous squash of the held result and of any input offered this cycle.
REQ-004 in_valid  input  1  InData holds an operand packet.
REQ-005 in_ready  output  1  stage accepts InData this cycle.
REQ-006 InData  input  58  operand packet; fields per REQ-012.
REQ-007 out_valid  output  1  outData holds a result packet.
REQ-008 out_ready  input  1  consumer takes outData this cycle.
REQ-009 outData  output  42  fields: [6:0] control; [22:7] result; [23] wr_en; [24] C; [25] Z; [41:26] operand B.

Function
REQ-010 Handshake: accept when in_valid && in_ready; in_ready = resetn && (!out_valid || out_ready).
REQ-011 Latency: an accepted packet in cycle N appears on outData with out_valid=1 in cycle N+1.
REQ-012 InData fields:
  - [1:0] fmt: 11 R, 10 I, 01 J, 00 NOP.
  - [4:2] op; [6:5] cond.
  - [25:10] old destination value.
  - [57:42] operand A.
  - [41:26] raw operand B.
REQ-013 Operand B by fmt:
  - R: [41:26].
  - I: sign-extended [31:26].
  - J: sign-extended [34:26].
REQ-014 fmt 00: packet accepted and dropped; no output, flags unchanged.
REQ-015 op codes:
  - 000 ADD A+B, 17-bit sum.
  - 001 NAND ~(A&B).
  - 010 SUB A-B, compare only, wr_en=0.
  - 011 LHI {InData[34:26], 7'd0}.
  - 100 PASS B.
  - 101-111 behave as ADD.
REQ-016 cond codes: 00 always; 01 only if C=1; 10 only if Z=1; 11 always. Flag values are those held when the packet is accepted.
REQ-017 Failed condition:
  - wr_en=0, result = InData[25:10], flags unchanged.
  - packet still emitted.
REQ-018 Flag update on executed ops:
  - ADD: C = sum bit 16, Z = (result==0).
  - NAND and SUB: Z only.
  - LHI and PASS: no flags.
REQ-019 outData C/Z reflect the flags after the op; operand B field carries the selected B; control carries InData[6:0].
REQ-020 Stall: while out_valid && !out_ready, outData and flags hold stable and no packet is accepted.
REQ-021 Flush:
  - next cycle out_valid=0.
  - a packet offered in the flush cycle is not accepted and does not touch flags.
  - flags otherwise retained.
REQ-022 Back-to-back: a dependent cond op accepted the cycle after a flag-writing op sees the updated flags.

Reset
REQ-023 While resetn=0 at clk edge: out_valid=0, outData=0, C=0, Z=0.
REQ-024 While resetn=0: in_ready=0.
REQ-025 Reset asserted mid-stall discards the held packet; flush and reset are not compared for priority (reset dominates).

Structure
REQ-026 Package risc_pkg holds:
  - fmt, op and cond code constants.
  - InData/outData field positions.
  - word width 16.
REQ-027 Sub-module alu16: combinational ADD/NAND/SUB/LHI/PASS, outputs result, carry, zero. Flags, condition logic and output register live in execute_stage.

Verification
REQ-028 R ADD, A=0xFFFF, B=0x0001, cond 00 -> next cycle: result 0x0000, C=1, Z=1, wr_en=1.
REQ-029 Then R ADD cond 01, A=2, B=3:
  - result 5, wr_en=1, C=0, Z=0.
  - repeated with cond 01: result = old dest value, wr_en=0, flags unchanged.
REQ-030 I ADD, A=5, [31:26]=6'h3E -> result 0x0003, C=1; J LHI, [34:26]=9'h1FF -> result 0xFF80, flags unchanged.
REQ-031 out_ready=0 for 3 cycles with a held result and in_valid=1:
  - outData constant, in_ready=0.
  - second packet accepted only on the release cycle, emitted one cycle later.
REQ-032 ADD producing carry offered with flush=1 -> no out_valid next cycle, C unchanged.
REQ-033 resetn=0 during stall -> out_valid=0, outData=0, C=Z=0 after the edge.
